tuner_pkt_sched: RTL



---
 rtl/tuner_pkg.sv | 25 ++
 rtl/tuner_pkt_sched_if.sv | 27 ++
 rtl/rr_pick4.sv | 26 ++
 rtl/tuner_pkt_sched.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared constants and types for the tuner packet scheduler and the packet mux it feeds.
package tuner_pkg;

  localparam int unsigned NSRC     = 4;
  localparam int unsigned HDR_LEN  = 4;
  localparam int unsigned TS_LEN   = 188;
  localparam int unsigned SLOT_LEN = HDR_LEN + TS_LEN;

  typedef logic [1:0] src_id_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_GRANT,
    ST_GAP
  } sched_state_t;

  function automatic logic [NSRC-1:0] id2oh(src_id_t id);
    logic [NSRC-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tuner_pkt_sched_if.sv
// Grant handshake between the packet scheduler (master) and the 4-to-1 packet mux / sources (slave).
interface tuner_pkt_sched_if;
  import tuner_pkg::*;

  logic [NSRC-1:0] PKT_READY;
  logic            SLOT_DONE;
  logic            GRANT_VALID;
  src_id_t         GRANT_ID;
  logic [NSRC-1:0] GRANT_OH;

  modport master (
    input  PKT_READY,
    input  SLOT_DONE,
    output GRANT_VALID,
    output GRANT_ID,
    output GRANT_OH
  );

  modport slave (
    output PKT_READY,
    output SLOT_DONE,
    input  GRANT_VALID,
    input  GRANT_ID,
    input  GRANT_OH
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority encoder: first set request scanning ptr, ptr+1, ... modulo 4.
module rr_pick4
  import tuner_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  src_id_t         ptr,
  output logic            valid,
  output src_id_t         idx
);

  src_id_t cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < NSRC; i++) begin
      cand = ptr + src_id_t'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tuner_pkt_sched.sv
// Weighted round-robin slot scheduler for four tuner TS sources, with per-source grant counters.
module tuner_pkt_sched
  import tuner_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned WW   = 4,
  parameter int unsigned CW   = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  tuner_pkt_sched_if.master    sif,
  input  logic [NSRC*WW-1:0]   CFG_WEIGHT,
  input  logic                 CFG_LOAD,
  output logic [CW-1:0]        GRANT_CNT_0,
  output logic [CW-1:0]        GRANT_CNT_1,
  output logic [CW-1:0]        GRANT_CNT_2,
  output logic [CW-1:0]        GRANT_CNT_3
);

  sched_state_t       state_q, state_d;
  logic [WW-1:0]      w_q   [NSRC];
  logic [WW-1:0]      c_q   [NSRC];
  logic [CW-1:0]      cnt_q [NSRC];
  logic [NSRC*WW-1:0] pend_w_q;
  logic               load_pend_q;
  src_id_t            ptr_q;
  src_id_t            gid_q;
  logic               gv_q;
  logic [NSRC-1:0]    goh_q;

  logic [NSRC-1:0]    elig;
  logic [NSRC-1:0]    reloadable;
  logic               pick_vld;
  src_id_t            pick_id;
  logic               do_grant;
  logic               do_reload;
  logic               do_close;
  logic               w_load_now;
  logic               w_load_pend;

  always_comb begin
    elig       = '0;
    reloadable = '0;
    for (int unsigned n = 0; n < NSRC; n++) begin
      elig[n]       = sif.PKT_READY[n] && (c_q[n] != '0);
      reloadable[n] = sif.PKT_READY[n] && (w_q[n] != '0);
    end
  end

  rr_pick4 u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_id)
  );

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_reload   = 1'b0;
    do_close    = 1'b0;
    w_load_now  = 1'b0;
    w_load_pend = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        w_load_now = CFG_LOAD;
        if (pick_vld) begin
          do_grant = 1'b1;
          state_d  = ST_GRANT;
        end else if (|reloadable) begin
          state_d = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        w_load_now = CFG_LOAD;
        do_reload  = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_GRANT: begin
        w_load_pend = CFG_LOAD;
        if (sif.SLOT_DONE) begin
          do_close = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        w_load_now = CFG_LOAD;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load deferred during a slot lands on the GAP->IDLE edge, so the first IDLE
  // decision after the slot already sees the new weights.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned n = 0; n < NSRC; n++) w_q[n] <= WW'(1);
      load_pend_q <= 1'b0;
      pend_w_q    <= '0;
    end else begin
      if (w_load_now) begin
        for (int unsigned n = 0; n < NSRC; n++) w_q[n] <= CFG_WEIGHT[n*WW +: WW];
      end else if (state_q == ST_GAP && load_pend_q) begin
        for (int unsigned n = 0; n < NSRC; n++) w_q[n] <= pend_w_q[n*WW +: WW];
      end
      if (w_load_pend) begin
        load_pend_q <= 1'b1;
        pend_w_q    <= CFG_WEIGHT;
      end else if (state_q == ST_GAP) begin
        load_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned n = 0; n < NSRC; n++) c_q[n] <= '0;
      ptr_q <= '0;
    end else begin
      if (do_reload) begin
        for (int unsigned n = 0; n < NSRC; n++) c_q[n] <= w_q[n];
      end else if (do_grant) begin
        c_q[pick_id] <= c_q[pick_id] - WW'(1);
      end
      // Source keeps priority while it still has credit this round.
      if (do_close) ptr_q <= (c_q[gid_q] == '0) ? gid_q + src_id_t'(1) : gid_q;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned n = 0; n < NSRC; n++) cnt_q[n] <= '0;
    end else if (do_grant) begin
      cnt_q[pick_id] <= cnt_q[pick_id] + CW'(1);
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      gv_q  <= 1'b0;
      gid_q <= '0;
      goh_q <= '0;
    end else if (do_grant) begin
      gv_q  <= 1'b1;
      gid_q <= pick_id;
      goh_q <= id2oh(pick_id);
    end else if (do_close) begin
      gv_q  <= 1'b0;
      goh_q <= '0;
    end
  end

  assign sif.GRANT_VALID = gv_q;
  assign sif.GRANT_ID    = gid_q;
  assign sif.GRANT_OH    = goh_q;
  assign GRANT_CNT_0     = cnt_q[0];
  assign GRANT_CNT_1     = cnt_q[1];
  assign GRANT_CNT_2     = cnt_q[2];
  assign GRANT_CNT_3     = cnt_q[3];

endmodule
